sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter in front of a single-port synchronous SRAM.
//
// Port 0 is the instruction side and port 1 is the data side. At most one port
// is granted per cycle. The grant is decided combinationally from the live
// request inputs and the registered arbitration state. A granted access drives
// the SRAM in the same cycle. Read data returns one cycle later on the port
// that issued the read.
//
// Ports
//   ACLK, ARESET       clock; synchronous active-high reset
//   reqN_i, weN_i      request and write select for port N (0 or 1)
//   addrN_i            word address for port N
//   wdataN_i, wstrbN_i write data and byte enables for port N
//   gntN_o             request of port N accepted this cycle
//   rvalidN_o          read data valid for port N
//   rdataN_o           read data for port N (0 when not valid)
//   CEB, WEB, A        SRAM chip enable (low), write enable (low), address
//   DI, BWEB           SRAM write data, bit write enable (low)
//   DO                 SRAM read data, valid one cycle after the read command
//
// Build option
//   SRAM_ARB_FIXED_PRIO_EN  port 1 wins every conflict and there is no
//                           round-robin pointer. The starvation guard still
//                           applies. Without the macro, conflicts are resolved
//                           round-robin.

module sram_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,

  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [31:0]       wdata0_i,
  input  logic [3:0]        wstrb0_i,

  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata1_i,
  input  logic [3:0]        wstrb1_i,

  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [31:0]       rdata0_o,
  output logic [31:0]       rdata1_o,

  output logic              CEB,
  output logic              WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  output logic [31:0]       BWEB,
  input  logic [31:0]       DO
);

  localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  // Identifies the port that owns the read data arriving on DO this cycle.
  typedef enum logic [1:0] {
    TagNone,
    TagP0,
    TagP1
  } tag_e;

  tag_e             tag_q, tag_d;
  logic [WaitW-1:0] wait0_q, wait0_d;
  logic [WaitW-1:0] wait1_q, wait1_d;

  logic gnt0, gnt1, gnt_any;
  logic starve0, starve1;
  logic prefer0;  // on a plain conflict, 1 lets port 0 win

  // Starvation guard. A counter can only be at its limit if the port has
  // requested continuously, but the live request is still required.
  assign starve0 = req0_i && (wait0_q == WaitMax);
  assign starve1 = req1_i && (wait1_q == WaitMax);

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign prefer0 = 1'b0;
`else
  // Names the last winner: 1 means port 1. Reset to 1 so port 0 takes the
  // first conflict.
  logic last_q, last_d;
  assign prefer0 = last_q;

  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = 1'b0;
    end else if (gnt1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Grant decision. Reset blocks all grants.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!ARESET) begin
      if (starve0) begin
        gnt0 = 1'b1;  // also covers both counters at the limit
      end else if (starve1) begin
        gnt1 = 1'b1;
      end else if (req0_i && req1_i) begin
        gnt0 = prefer0;
        gnt1 = !prefer0;
      end else begin
        gnt0 = req0_i;
        gnt1 = req1_i;
      end
    end
  end

  assign gnt_any = gnt0 | gnt1;
  assign gnt0_o  = gnt0;
  assign gnt1_o  = gnt1;

  // SRAM command. Port 1 fields are used only when port 1 holds the grant.
  logic              sel_we;
  logic [3:0]        sel_strb;

  always_comb begin
    sel_we   = gnt1 ? we1_i    : we0_i;
    sel_strb = gnt1 ? wstrb1_i : wstrb0_i;
    A        = gnt1 ? addr1_i  : addr0_i;
    DI       = gnt1 ? wdata1_i : wdata0_i;
    CEB      = !gnt_any;
    WEB      = !(gnt_any && sel_we);
    BWEB     = '1;
    if (gnt_any && sel_we) begin
      for (int k = 0; k < 4; k++) begin
        BWEB[8*k +: 8] = {8{~sel_strb[k]}};
      end
    end
  end

  // Wait counters: count refused cycles while requesting and saturate at the
  // limit. Clear when the port is granted or stops requesting.
  always_comb begin
    wait0_d = wait0_q;
    if (!req0_i || gnt0) begin
      wait0_d = '0;
    end else if (wait0_q != WaitMax) begin
      wait0_d = wait0_q + WaitW'(1);
    end

    wait1_d = wait1_q;
    if (!req1_i || gnt1) begin
      wait1_d = '0;
    end else if (wait1_q != WaitMax) begin
      wait1_d = wait1_q + WaitW'(1);
    end
  end

  // The response tag loads on every cycle and is set only by a granted read.
  always_comb begin
    tag_d = TagNone;
    if (gnt0 && !we0_i) begin
      tag_d = TagP0;
    end else if (gnt1 && !we1_i) begin
      tag_d = TagP1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tag_q   <= TagNone;
      wait0_q <= '0;
      wait1_q <= '0;
    end else begin
      tag_q   <= tag_d;
      wait0_q <= wait0_d;
      wait1_q <= wait1_d;
    end
  end

  // The tag still holds a read issued just before reset asserted. Gating with
  // ARESET drops that response.
  always_comb begin
    rvalid0_o = (tag_q == TagP0) && !ARESET;
    rvalid1_o = (tag_q == TagP1) && !ARESET;
    rdata0_o  = rvalid0_o ? DO : 32'h0;
    rdata1_o  = rvalid1_o ? DO : 32'h0;
  end

endmodule
